// File: rtl/speccfa_pkg.sv
// Shared types and default widths for the multi-lane SpecCFA detector.
package speccfa_pkg;
  localparam int D_AW         = 16;
  localparam int D_LEN_W      = 8;
  localparam int D_ID_W       = 8;
  localparam int D_LANES      = 2;
  localparam int D_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, MONITOR, DETECT} lane_state_e;

  typedef struct packed {
    logic [D_ID_W-1:0]  id;
    logic [D_LEN_W-1:0] len;
    logic [D_AW-1:0]    cflog_addr;
    logic [2:0]         lane;
  } det_rec_t;
endpackage

// File: rtl/speccfa_if.sv
// Detection FIFO head handshake between the detector and the log manager.
interface speccfa_if #(
  parameter int AW    = 16,
  parameter int LEN_W = 8,
  parameter int ID_W  = 8
);
  logic             det_valid;
  logic             det_ready;
  logic [ID_W-1:0]  det_id;
  logic [LEN_W-1:0] det_len;
  logic [AW-1:0]    det_cflog_addr;
  logic [2:0]       det_lane;

  modport master (output det_valid, det_id, det_len, det_cflog_addr, det_lane, input det_ready);
  modport slave  (input det_valid, det_id, det_len, det_cflog_addr, det_lane, output det_ready);
endinterface

// File: rtl/speccfa_lane.sv
// One match lane: walks its block region, tracks the expected entry and holds one pending detection.
module speccfa_lane import speccfa_pkg::*; #(
  parameter int AW       = D_AW,
  parameter int LEN_W    = D_LEN_W,
  parameter int ID_W     = D_ID_W,
  parameter int LANE_IDX = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wen,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dest,
  input  logic [AW-1:0]    log_ptr,
  input  logic [AW-1:0]    min,
  input  logic [AW-1:0]    max,
  input  logic [AW-1:0]    entry_src,
  input  logic [AW-1:0]    entry_dest,
  input  logic [LEN_W-1:0] len,
  input  logic [ID_W-1:0]  id,
  input  logic             pend_clr,
  output logic [AW-1:0]    base,
  output logic [LEN_W-1:0] ptr,
  output logic             pend_vld,
  output det_rec_t         pend_rec,
  output logic             ovf_set
);
  lane_state_e      state, state_nxt;
  logic [AW-1:0]    base_nxt, rec_addr, rec_nxt, adv_sum, adv_base;
  logic [LEN_W-1:0] ptr_nxt;
  logic             hit, src_hit, load;

  assign hit      = wen && src == entry_src && dest == entry_dest;
  assign src_hit  = wen && src == entry_src && dest != entry_dest;
  // Next block header sits right after this block's 2*len entry words.
  assign adv_sum  = base + AW'({len, 1'b1});
  assign adv_base = (adv_sum >= max - min) ? '0 : adv_sum;

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    ptr_nxt   = ptr;
    rec_nxt   = rec_addr;
    load      = 1'b0;
    unique case (state)
      IDLE:
        if (len == '0) base_nxt = adv_base;
        else if (hit) begin
          rec_nxt = log_ptr;
          if (len == LEN_W'(1)) state_nxt = DETECT;
          else begin
            state_nxt = MONITOR;
            ptr_nxt   = LEN_W'(1);
          end
        end else if (src_hit) base_nxt = adv_base;
      MONITOR:
        if (hit) begin
          if (ptr == len - LEN_W'(1)) state_nxt = DETECT;
          else ptr_nxt = ptr + LEN_W'(1);
        end else if (wen) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      DETECT: begin
        load      = 1'b1;
        base_nxt  = adv_base;
        ptr_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A slot being drained by the arbiter this cycle can take the new record.
  assign ovf_set = load && pend_vld && !pend_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      base     <= '0;
      ptr      <= '0;
      rec_addr <= '0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      ptr      <= ptr_nxt;
      rec_addr <= rec_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld <= 1'b0;
      pend_rec <= '0;
    end else begin
      if (pend_clr) pend_vld <= 1'b0;
      if (load && (!pend_vld || pend_clr)) begin
        pend_vld            <= 1'b1;
        pend_rec.id         <= id;
        pend_rec.len        <= len;
        pend_rec.cflog_addr <= rec_addr;
        pend_rec.lane       <= 3'(LANE_IDX);
      end
    end
  end
endmodule

// File: rtl/speccfa_multi.sv
// Multi-lane SpecCFA detector: lanes, pending-slot arbiter and detection FIFO.
// Optional bus memory protection is built when SPECCFA_MEMPROT_EN is defined.
module speccfa_multi import speccfa_pkg::*; #(
  parameter int AW         = D_AW,
  parameter int LEN_W      = D_LEN_W,
  parameter int ID_W       = D_ID_W,
  parameter int LANES      = D_LANES,
  parameter int FIFO_DEPTH = D_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cflow_hw_wen,
  input  logic [AW-1:0]               cflow_src,
  input  logic [AW-1:0]               cflow_dest,
  input  logic [AW-1:0]               cflow_log_ptr,
  input  logic [LANES-1:0][AW-1:0]    lane_min,
  input  logic [LANES-1:0][AW-1:0]    lane_max,
  input  logic [LANES-1:0][AW-1:0]    lane_entry_src,
  input  logic [LANES-1:0][AW-1:0]    lane_entry_dest,
  input  logic [LANES-1:0][LEN_W-1:0] lane_len,
  input  logic [LANES-1:0][ID_W-1:0]  lane_id,
  output logic [LANES-1:0][AW-1:0]    lane_base,
  output logic [LANES-1:0][LEN_W-1:0] lane_ptr,
  speccfa_if.master                   det,
  output logic                        overflow,
  input  logic                        data_wr,
  input  logic                        dma_en,
  input  logic [AW-1:0]               data_addr,
  input  logic [AW-1:0]               dma_addr,
  output logic                        violation
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [LANES-1:0] pend_vld, pend_clr, ovf_set;
  det_rec_t         pend_rec [LANES];
  det_rec_t         fifo_mem [FIFO_DEPTH];
  det_rec_t         sel_rec, head;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic             found, push_ok, push, pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    speccfa_lane #(.AW(AW), .LEN_W(LEN_W), .ID_W(ID_W), .LANE_IDX(g)) u_lane (
      .clk, .reset_n,
      .wen(cflow_hw_wen), .src(cflow_src), .dest(cflow_dest), .log_ptr(cflow_log_ptr),
      .min(lane_min[g]), .max(lane_max[g]),
      .entry_src(lane_entry_src[g]), .entry_dest(lane_entry_dest[g]),
      .len(lane_len[g]), .id(lane_id[g]),
      .pend_clr(pend_clr[g]),
      .base(lane_base[g]), .ptr(lane_ptr[g]),
      .pend_vld(pend_vld[g]), .pend_rec(pend_rec[g]), .ovf_set(ovf_set[g])
    );
  end

  assign pop     = det.det_valid && det.det_ready;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push_ok = (count != (PW+1)'(FIFO_DEPTH)) || pop;
  assign push    = found && push_ok;

  always_comb begin
    found    = 1'b0;
    sel_rec  = '0;
    pend_clr = '0;
    for (int i = 0; i < LANES; i++)
      if (pend_vld[i] && !found) begin
        found       = 1'b1;
        sel_rec     = pend_rec[i];
        pend_clr[i] = push_ok;
      end
  end

  always_ff @(posedge clk) if (push) fifo_mem[wr_ptr] <= sel_rec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (|ovf_set) overflow <= 1'b1;
    end
  end

  assign head               = (count != '0) ? fifo_mem[rd_ptr] : '0;
  assign det.det_valid      = count != '0;
  assign det.det_id         = head.id;
  assign det.det_len        = head.len;
  assign det.det_cflog_addr = head.cflog_addr;
  assign det.det_lane       = head.lane;

`ifdef SPECCFA_MEMPROT_EN
  always_comb begin
    violation = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (data_wr && data_addr >= lane_min[i] && data_addr <= lane_max[i]) violation = 1'b1;
      if (dma_en && dma_addr >= lane_min[i] && dma_addr <= lane_max[i]) violation = 1'b1;
    end
  end
`else
  logic unused_bus;
  assign unused_bus = ^{data_wr, dma_en, data_addr, dma_addr};
  assign violation  = 1'b0;
`endif
endmodule
